div_eu: RTL and testbench
=========================

Name: div_eu

Overview:
- Iterative radix-2 integer divide execution unit on the EU side of the reservation-station/EU handshake.
- Accepts one operation from the reservation station: control, two operands and the RS entry index.
- Computes RISC-V DIV/DIVU/REM/REMU and returns the result with the same entry index.
- Sits beside the FP and ALU units, behind its own generic reservation station.

Parameters:
- XLEN, 64, operand/result width (len5_pkg::XLEN).
- RS_DEPTH, 4, depth of the owning reservation station; entry index width is $clog2(RS_DEPTH).
- EU_CTL_LEN, 2, control width.
- EXCEPT_LEN, 2, exception code width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort of any operation in flight
- valid_i  in  1  RS presents an operation
- ready_o  out  1  EU can accept an operation
- ctl_i  in  EU_CTL_LEN  0=DIV, 1=DIVU, 2=REM, 3=REMU
- entry_idx_i  in  $clog2(RS_DEPTH)  RS entry tag
- rs1_i  in  XLEN  dividend
- rs2_i  in  XLEN  divisor
- valid_o  out  1  result available
- ready_i  in  1  RS accepts the result
- entry_idx_o  out  $clog2(RS_DEPTH)  tag of the result
- result_o  out  XLEN  quotient or remainder
- except_raised_o  out  1  always 0 (divide raises no exception)
- except_code_o  out  EXCEPT_LEN  always 0

Behaviour:
- One clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: state IDLE, ready_o=1, valid_o=0, result_o=0, entry_idx_o=0, except_raised_o=0, except_code_o=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready_o=1.
    - On valid_i, latch ctl, tag, |rs1| and |rs2| (magnitudes for signed ops), and quotient/remainder sign flags.
    - Clear the partial remainder, load counter=XLEN-1, go to BUSY.
  - BUSY: ready_o=0, valid_o=0.
    - Each cycle: shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient LSB on no borrow.
    - Counter decrements.
    - When the iteration with counter==0 completes, register the final sign-corrected result and go to DONE.
  - DONE: valid_o=1, ready_o=0.
    - Result and tag are held stable while ready_i=0.
    - valid_o && ready_i moves to IDLE; a new op can be accepted the following cycle, not the same cycle.
- Latency: op accepted at edge T, valid_o high from cycle T+XLEN+1 (65 cycles for XLEN=64); throughput one op per XLEN+2 cycles minimum.
- Sign rules:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - Negation is two's complement, modulo 2^XLEN.
- Special cases, identical results to RISC-V spec:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1=0x8000_0000_0000_0000, rs2=-1): DIV -> rs1, REM -> 0.
  - Both are still produced after the full XLEN-cycle latency unless the optional feature is enabled.
- flush_i: in any state, next cycle state=IDLE, valid_o=0; result is discarded. flush_i has priority over valid_i in IDLE; no op is accepted that cycle.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro DIV_EU_FAST_SPECIAL_EN.
- When defined, the following ops skip BUSY and go IDLE->DONE with valid_o high at T+1:
  - divisor zero;
  - signed overflow;
  - unsigned |rs1| < |rs2| (quotient 0, remainder rs1).
- When not defined, every op takes XLEN+1 cycles; results are identical in both builds.

Test Plan:
- DIVU 100/7, tag 2 -> valid_o at T+65, result 14, entry_idx_o 2; REMU same operands -> 2.
- DIV rs1=-7, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero: DIVU 5/0 -> all ones, REM 5/0 -> 5, except_raised_o=0.
  - With DIV_EU_FAST_SPECIAL_EN: valid_o at T+1.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM -> 0.
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> valid_o, result_o, entry_idx_o stable, ready_o=0; ready_i=1 -> IDLE next cycle, ready_o=1.
- flush_i at cycle 20 of BUSY -> IDLE next cycle, no valid_o; subsequent DIVU 9/3 -> result 3 with correct tag.

Source files
------------

// File: rtl/div_eu.sv
// rtl/div_eu.sv - iterative radix-2 DIV/DIVU/REM/REMU execution unit with RS handshake
// Optional early-out for divisor zero, signed overflow and |rs1| < |rs2|: DIV_EU_FAST_SPECIAL_EN
module div_eu #(
    parameter int XLEN       = 64,
    parameter int RS_DEPTH   = 4,
    parameter int EU_CTL_LEN = 2,
    parameter int EXCEPT_LEN = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        flush_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [EU_CTL_LEN-1:0]       ctl_i,
    input  logic [$clog2(RS_DEPTH)-1:0] entry_idx_i,
    input  logic [XLEN-1:0]             rs1_i,
    input  logic [XLEN-1:0]             rs2_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(RS_DEPTH)-1:0] entry_idx_o,
    output logic [XLEN-1:0]             result_o,
    output logic                        except_raised_o,
    output logic [EXCEPT_LEN-1:0]       except_code_o
);

    localparam int IDXW = $clog2(RS_DEPTH);
    localparam int CNTW = $clog2(XLEN);

`ifdef DIV_EU_FAST_SPECIAL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;
    logic [IDXW-1:0]   r_tag;
    logic              r_is_rem;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_div;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quot;
    logic [CNTW-1:0]   r_cnt;

    logic              w_signed;
    logic              w_is_rem;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_small;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic              w_no_borrow;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quot_nx;
    logic [XLEN-1:0]   w_q_fin;
    logic [XLEN-1:0]   w_r_fin;

    // ctl_i[0] selects unsigned, ctl_i[1] selects remainder
    assign w_signed = ~ctl_i[0];
    assign w_is_rem = ctl_i[1];
    assign w_s1     = w_signed & rs1_i[XLEN-1];
    assign w_s2     = w_signed & rs2_i[XLEN-1];
    assign w_abs1   = w_s1 ? -rs1_i : rs1_i;
    assign w_abs2   = w_s2 ? -rs2_i : rs2_i;
    assign w_div0   = (rs2_i == '0);
    assign w_ovf    = w_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    assign w_small  = (w_abs1 < w_abs2);
    assign w_fast   = w_div0 | w_ovf | w_small;

    always_comb begin
        w_fast_res = '0;
        if (w_div0) begin
            w_fast_res = w_is_rem ? rs1_i : '1;
        end else if (w_ovf) begin
            w_fast_res = w_is_rem ? '0 : rs1_i;
        end else begin
            w_fast_res = w_is_rem ? rs1_i : '0;
        end
    end

    // Restoring step: the remainder stays below the divisor, so one guard bit suffices
    assign w_rem_sh    = {r_rem, r_quot[XLEN-1]};
    assign w_trial     = w_rem_sh - {1'b0, r_div};
    assign w_no_borrow = ~w_trial[XLEN];
    assign w_rem_nx    = w_no_borrow ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quot_nx   = {r_quot[XLEN-2:0], w_no_borrow};
    assign w_q_fin     = r_neg_q ? -w_quot_nx : w_quot_nx;
    assign w_r_fin     = r_neg_r ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_tag    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_tag    <= entry_idx_i;
                        r_is_rem <= w_is_rem;
                        // A zero divisor must yield all ones regardless of operand signs
                        r_neg_q  <= (w_s1 ^ w_s2) & ~w_div0;
                        r_neg_r  <= w_s1;
                        r_div    <= w_abs2;
                        r_quot   <= w_abs1;
                        r_rem    <= '0;
                        r_cnt    <= CNTW'(XLEN - 1);
                        r_ready  <= 1'b0;
                        if (FAST_EN && w_fast) begin
                            r_result <= w_fast_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= w_quot_nx;
                    r_cnt  <= r_cnt - CNTW'(1);
                    if (r_cnt == '0) begin
                        r_result <= r_is_rem ? w_r_fin : w_q_fin;
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o         = r_ready;
    assign valid_o         = r_valid;
    assign result_o        = r_result;
    assign entry_idx_o     = r_tag;
    assign except_raised_o = 1'b0;
    assign except_code_o   = '0;

endmodule

// File: tb/tb_div_eu.sv
// tb/tb_div_eu.sv - scoreboard testbench for div_eu (honours DIV_EU_FAST_SPECIAL_EN)
module tb_div_eu;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic [1:0]  ctl = 2'd0;
    logic [1:0]  idx_in = 2'd0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        ready_out;
    logic        valid_out;
    logic [1:0]  idx_out;
    logic [63:0] result;
    logic        exc_raised;
    logic [1:0]  exc_code;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  idx;
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div_eu dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_i        (flush),
        .valid_i        (valid_in),
        .ready_o        (ready_out),
        .ctl_i          (ctl),
        .entry_idx_i    (idx_in),
        .rs1_i          (op_a),
        .rs2_i          (op_b),
        .valid_o        (valid_out),
        .ready_i        (ready_in),
        .entry_idx_o    (idx_out),
        .result_o       (result),
        .except_raised_o(exc_raised),
        .except_code_o  (exc_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
        logic ovf;
        ovf = (x == MIN64) && (y == ONES);
        case (c)
            2'd0:    return (y == 0) ? ONES : (ovf ? x : 64'($signed(x) / $signed(y)));
            2'd1:    return (y == 0) ? ONES : x / y;
            2'd2:    return (y == 0) ? x : (ovf ? 64'd0 : 64'($signed(x) % $signed(y)));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y);
`ifdef DIV_EU_FAST_SPECIAL_EN
        logic [63:0] ax;
        logic [63:0] ay;
        ax = (!c[0] && x[63]) ? -x : x;
        ay = (!c[0] && y[63]) ? -y : y;
        if (y == 0 || (!c[0] && x == MIN64 && y == ONES) || ax < ay) return 1;
`endif
        return 65;
    endfunction

    task automatic drive_op(input logic [1:0] c, input logic [1:0] t, input logic [63:0] x,
                            input logic [63:0] y, input logic [63:0] res, input bit push);
        exp_t e;
        ctl = c; idx_in = t; op_a = x; op_b = y; valid_in = 1'b1;
        if (push) begin
            e.idx = t; e.res = res; e.lat = exp_lat(c, x, y);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic collect(output int lat);
        lat = 1;
        while (valid_out !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result;
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        total++; if (idx_out !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", idx_out); end
        total++; if ({exc_raised, exc_code} !== 3'd0) begin bad++; $display("FAIL reset_except: got %b want 000", {exc_raised, exc_code}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_table(input string name, input logic [1:0] cs[], input logic [1:0] ts[],
                             input logic [63:0] xs[], input logic [63:0] ys[], input logic [63:0] rs[]);
        int   lat;
        exp_t e;
        for (int i = 0; i < cs.size(); i++) begin
            drive_op(cs[i], ts[i], xs[i], ys[i], rs[i], 1'b1);
            collect(lat);
            e = sb.pop_front();
            total++; if (valid_out !== 1'b1 || lat != e.lat) begin bad++; $display("FAIL %s[%0d] latency: got %0d (valid=%b) want %0d", name, i, lat, valid_out, e.lat); end
            total++; if (result !== e.res) begin bad++; $display("FAIL %s[%0d] result: got %h want %h", name, i, result, e.res); end
            total++; if (idx_out !== e.idx) begin bad++; $display("FAIL %s[%0d] tag: got %0d want %0d", name, i, idx_out, e.idx); end
            total++; if (exc_raised !== 1'b0 || exc_code !== 2'd0) begin bad++; $display("FAIL %s[%0d] except: got %b/%0d want 0/0", name, i, exc_raised, exc_code); end
            release_result();
        end
    endtask

    task automatic test_unsigned;
        run_table("unsigned", '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1},
                  '{2'd2, 2'd2, 2'd1, 2'd3, 2'd0},
                  '{64'd100, 64'd100, ONES, 64'd12345678901, MIN64},
                  '{64'd7, 64'd7, 64'd3, 64'd1000, ONES},
                  '{64'd14, 64'd2, 64'h5555_5555_5555_5555, 64'd901, 64'd0});
    endtask

    task automatic test_signed;
        run_table("signed", '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2},
                  '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2},
                  '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'd7,
                    64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9},
                  '{64'd2, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE},
                  '{64'hFFFF_FFFF_FFFF_FFFD, ONES, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64'd3, ONES});
    endtask

    task automatic test_div_zero;
        run_table("divzero", '{2'd1, 2'd2, 2'd0, 2'd3},
                  '{2'd3, 2'd1, 2'd2, 2'd0},
                  '{64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd5},
                  '{64'd0, 64'd0, 64'd0, 64'd0},
                  '{ONES, 64'd5, ONES, 64'd5});
    endtask

    task automatic test_overflow;
        run_table("overflow", '{2'd0, 2'd2},
                  '{2'd1, 2'd2},
                  '{MIN64, MIN64},
                  '{ONES, ONES},
                  '{MIN64, 64'd0});
    endtask

    task automatic test_backpressure;
        int          lat;
        exp_t        e;
        logic [63:0] held_res;
        logic [1:0]  held_idx;
        drive_op(2'd1, 2'd3, 64'd1000, 64'd10, 64'd100, 1'b1);
        collect(lat);
        e = sb.pop_front();
        total++; if (valid_out !== 1'b1 || result !== e.res || idx_out !== e.idx) begin bad++; $display("FAIL bp_first: got v=%b %h tag %0d want 1 %h tag %0d", valid_out, result, idx_out, e.res, e.idx); end
        held_res = e.res;
        held_idx = e.idx;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (valid_out !== 1'b1 || ready_out !== 1'b0 || result !== held_res || idx_out !== held_idx) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b r=%b %h tag %0d want v=1 r=0 %h tag %0d", i, valid_out, ready_out, result, idx_out, held_res, held_idx);
            end
        end
        release_result();
        total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL bp_release: got r=%b v=%b want r=1 v=0", ready_out, valid_out); end
    endtask

    task automatic test_flush;
        int   seen;
        int   lat;
        exp_t e;
        drive_op(2'd1, 2'd2, 64'd50, 64'd5, 64'd10, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL flush_idle: got r=%b v=%b want r=1 v=0", ready_out, valid_out); end
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (valid_out === 1'b1) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
        ctl = 2'd1; idx_in = 2'd3; op_a = 64'd8; op_b = 64'd0; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL flush_priority: got r=%b v=%b want r=1 v=0", ready_out, valid_out); end
        drive_op(2'd1, 2'd1, 64'd9, 64'd3, 64'd3, 1'b1);
        collect(lat);
        e = sb.pop_front();
        total++; if (valid_out !== 1'b1 || lat != e.lat) begin bad++; $display("FAIL flush_after latency: got %0d want %0d", lat, e.lat); end
        total++; if (result !== e.res || idx_out !== e.idx) begin bad++; $display("FAIL flush_after result: got %h tag %0d want %h tag %0d", result, idx_out, e.res, e.idx); end
        release_result();
    endtask

    task automatic test_back_to_back;
        int          lat;
        exp_t        e;
        exp_t        n;
        logic [1:0]  c;
        logic [63:0] x;
        logic [63:0] y;
        c = 2'($urandom_range(0, 3)); x = {$urandom, $urandom}; y = 64'($urandom_range(1, 1000));
        drive_op(c, 2'd0, x, y, model(c, x, y), 1'b1);
        for (int i = 0; i < 6; i++) begin
            collect(lat);
            e = sb.pop_front();
            total++; if (valid_out !== 1'b1 || lat != e.lat) begin bad++; $display("FAIL b2b[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            total++; if (result !== e.res || idx_out !== e.idx) begin bad++; $display("FAIL b2b[%0d] result: got %h tag %0d want %h tag %0d", i, result, idx_out, e.res, e.idx); end
            if (i < 5) begin
                c = 2'($urandom_range(0, 3));
                x = {$urandom, $urandom};
                case (i % 3)
                    0: y = {$urandom, $urandom};
                    1: y = 64'($urandom_range(1, 1000));
                    default: y = (i == 2) ? 64'd0 : -64'($urandom_range(1, 50));
                endcase
                ctl = c; idx_in = 2'(i + 1); op_a = x; op_b = y; valid_in = 1'b1; ready_in = 1'b1;
                n.idx = 2'(i + 1); n.res = model(c, x, y); n.lat = exp_lat(c, x, y);
                sb.push_back(n);
                @(posedge clk); #1;
                ready_in = 1'b0;
                total++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin bad++; $display("FAIL b2b[%0d] same_cycle_accept: got r=%b v=%b want r=1 v=0", i, ready_out, valid_out); end
                @(posedge clk); #1;
                valid_in = 1'b0;
            end else begin
                release_result();
            end
        end
    endtask

    task automatic test_reset_mid;
        drive_op(2'd0, 2'd2, 64'd1000, 64'd7, 64'd142, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || result !== 64'd0 || idx_out !== 2'd0) begin
            bad++; $display("FAIL reset_mid: got r=%b v=%b %h tag %0d want r=1 v=0 0 tag 0", ready_out, valid_out, result, idx_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
